cache_flush_ctrl: RTL

- Cache-level flush coordinator: the initiator side of the per-bank flush handshake.
- Accepts flush requests from core request lanes and locks the core bus.
- Drains outstanding core requests, then pulses flush_begin to every bank.
- Collects each bank's one-cycle flush_end pulse, then returns a flush response to every lane that requested.

---
 rtl/cache_flush_ctrl_pkg.sv | 25 ++
 rtl/cache_flush_pending.sv | 68 ++++++
 rtl/cache_flush_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_flush_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cache_flush_ctrl_pkg
//
// Shared definitions for the cache flush coordinator:
//   - flush_state_e : flush sequencer states (3-bit encoding)
//                     IDLE=0, DRAIN=1, BEGIN=2, WAIT=3, RESP=4
//   - pending_width : width of the outstanding-request counter, large enough
//                     to hold the value PENDING_SIZE itself.
// ----------------------------------------------------------------------------
package cache_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_BEGIN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } flush_state_e;

    // The counter must be able to represent 0..size inclusive.
    function automatic int pending_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/cache_flush_pending.sv
// ----------------------------------------------------------------------------
// cache_flush_pending
//
// Outstanding core request tracker. Counts core request handshakes up and core
// response handshakes down, both by population count, with increments and
// decrements in the same cycle applied as a single net update. The counter
// runs in every state of the flush sequencer, so handshakes in the cycle a
// flush is accepted are still tracked.
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-high reset (count -> 0)
//   core_req_fire in   [NUM_REQS] request handshakes this cycle
//   core_rsp_fire in   [NUM_REQS] response handshakes this cycle
//   pending_zero  out  registered flag: outstanding count is zero
// ----------------------------------------------------------------------------
module cache_flush_pending
    import cache_flush_ctrl_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int PENDING_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] core_req_fire,
    input  logic [NUM_REQS-1:0] core_rsp_fire,
    output logic                pending_zero
);

    localparam int PW = pending_width(PENDING_SIZE);
    localparam int CW = $clog2(NUM_REQS + 1);

    logic [PW-1:0] pending;
    logic [PW-1:0] pending_next;
    logic [CW-1:0] inc;
    logic [CW-1:0] dec;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            inc = inc + CW'(core_req_fire[i]);
            dec = dec + CW'(core_rsp_fire[i]);
        end
        pending_next = pending + PW'(inc) - PW'(dec);
    end

    // The zero flag is registered together with the count so the sequencer
    // sees a clean flop output rather than a wide compare on the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            pending_zero <= 1'b1;
        end else begin
            pending      <= pending_next;
            pending_zero <= (pending_next == '0);
        end
    end

    // The counter is sized for exactly PENDING_SIZE outstanding requests.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        (int'(pending) + int'(inc) - int'(dec)) <= PENDING_SIZE);

    // A response can only retire a request already counted or counted now.
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        int'(dec) <= (int'(pending) + int'(inc)));

endmodule

// File: rtl/cache_flush_ctrl.sv
// ----------------------------------------------------------------------------
// cache_flush_ctrl
//
// Cache-level flush coordinator (initiator side of the per-bank flush
// handshake). Accepts flush requests from the core lanes, locks the core bus,
// waits for outstanding core requests to drain, pulses flush_begin to every
// bank, collects each bank's one-cycle flush_end pulse and finally returns a
// flush response to every lane that was part of the accepted request.
//
// Sequence: IDLE -> DRAIN -> BEGIN -> WAIT -> RESP -> IDLE. All outputs are
// decoded from registered state only (Moore).
//
// Ports:
//   clk              in   clock
//   reset            in   asynchronous active-high reset; aborts any flush
//   flush_req_valid  in   [NUM_REQS]  per-lane flush request
//   flush_req_ready  out  [NUM_REQS]  per-lane accept (all ones in IDLE only)
//   flush_rsp_valid  out  [NUM_REQS]  per-lane completion
//   flush_rsp_ready  in   [NUM_REQS]  per-lane completion accept
//   core_req_fire    in   [NUM_REQS]  non-flush core request handshakes
//   core_rsp_fire    in   [NUM_REQS]  core response handshakes
//   core_bus_lock    out  blocks new core requests while a flush is active
//   bank_flush_begin out  [NUM_BANKS] one-cycle flush start pulse
//   bank_flush_end   in   [NUM_BANKS] one-cycle completion pulse per bank
//   flush_busy       out  sequencer is not IDLE
//
// Optional build macro CACHE_FLUSH_PERF_EN adds:
//   perf_flush_count  out [32] number of accepted flushes (wraps)
//   perf_flush_cycles out [32] cycles spent with flush_busy high (wraps)
// ----------------------------------------------------------------------------
module cache_flush_ctrl
    import cache_flush_ctrl_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int NUM_BANKS    = 4,
    parameter int PENDING_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQS-1:0]  flush_req_valid,
    output logic [NUM_REQS-1:0]  flush_req_ready,
    output logic [NUM_REQS-1:0]  flush_rsp_valid,
    input  logic [NUM_REQS-1:0]  flush_rsp_ready,
    input  logic [NUM_REQS-1:0]  core_req_fire,
    input  logic [NUM_REQS-1:0]  core_rsp_fire,
    output logic                 core_bus_lock,
    output logic [NUM_BANKS-1:0] bank_flush_begin,
    input  logic [NUM_BANKS-1:0] bank_flush_end,
    output logic                 flush_busy
`ifdef CACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]          perf_flush_count,
    output logic [31:0]          perf_flush_cycles
`endif
);

    localparam logic [NUM_BANKS-1:0] BANKS_ALL = '1;

    flush_state_e         state;
    flush_state_e         state_next;
    logic [NUM_REQS-1:0]  lane_mask;
    logic [NUM_REQS-1:0]  lane_mask_next;
    logic [NUM_BANKS-1:0] bank_done;
    logic [NUM_BANKS-1:0] bank_done_next;
    logic                 pending_zero;

    // ------------------------------------------------------------------
    // Outstanding core request tracking
    // ------------------------------------------------------------------
    cache_flush_pending #(
        .NUM_REQS     (NUM_REQS),
        .PENDING_SIZE (PENDING_SIZE)
    ) u_pending (
        .clk           (clk),
        .reset         (reset),
        .core_req_fire (core_req_fire),
        .core_rsp_fire (core_rsp_fire),
        .pending_zero  (pending_zero)
    );

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lane_mask <= '0;
            bank_done <= '0;
        end else begin
            state     <= state_next;
            lane_mask <= lane_mask_next;
            bank_done <= bank_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        lane_mask_next   = lane_mask;
        bank_done_next   = bank_done;
        flush_req_ready  = '0;
        flush_rsp_valid  = '0;
        bank_flush_begin = '0;
        core_bus_lock    = 1'b1;

        case (state)
            ST_IDLE: begin
                core_bus_lock   = 1'b0;
                flush_req_ready = '1;
                // Every lane asking in this cycle joins the same flush.
                if (|flush_req_valid) begin
                    lane_mask_next = flush_req_valid;
                    state_next     = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (pending_zero) begin
                    state_next = ST_BEGIN;
                end
            end

            ST_BEGIN: begin
                bank_flush_begin = '1;
                bank_done_next   = '0;
                state_next       = ST_WAIT;
            end

            ST_WAIT: begin
                // Including this cycle's pulses lets the last bank's end
                // move us to RESP without an extra cycle. Repeated pulses
                // from a finished bank are absorbed by the OR.
                bank_done_next = bank_done | bank_flush_end;
                if (bank_done_next == BANKS_ALL) begin
                    state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                flush_rsp_valid = lane_mask;
                lane_mask_next  = lane_mask & ~flush_rsp_ready;
                if (lane_mask_next == '0) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                core_bus_lock = 1'b0;
                state_next    = ST_IDLE;
            end
        endcase
    end

    assign flush_busy = (state != ST_IDLE);

`ifdef CACHE_FLUSH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_flush_count  <= '0;
            perf_flush_cycles <= '0;
        end else begin
            if (state == ST_IDLE && state_next == ST_DRAIN) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
            if (flush_busy) begin
                perf_flush_cycles <= perf_flush_cycles + 32'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Protocol checks on the environment
    // ------------------------------------------------------------------
    a_end_only_in_wait : assert property (@(posedge clk) disable iff (reset)
        (state == ST_WAIT) || (bank_flush_end == '0));

    a_no_req_when_locked : assert property (@(posedge clk) disable iff (reset)
        !(core_bus_lock && (|core_req_fire)));

endmodule
